// File: rtl/down_timer.sv
// Loadable down-counter with programmable prescale, one-shot/periodic modes,
// pause via enable and abort. The single terminal-count pulse is done_o.
module down_timer #(
    parameter int Bits         = 8,
    parameter int PrescaleBits = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [Bits-1:0]         load_val_i,
    input  logic                    periodic_i,
    input  logic [PrescaleBits-1:0] prescale_i,
    input  logic                    en_i,
    input  logic                    abort_i,
    output logic [Bits-1:0]         count_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [Bits-1:0]         CNT_ZERO   = {Bits{1'b0}};
    localparam logic [Bits-1:0]         CNT_ONE    = {{(Bits-1){1'b0}}, 1'b1};
    localparam logic [PrescaleBits-1:0] PRESC_ZERO = {PrescaleBits{1'b0}};
    localparam logic [PrescaleBits-1:0] PRESC_ONE  = {{(PrescaleBits-1){1'b0}}, 1'b1};

    state_t                  state_r;
    logic [Bits-1:0]         reload_r;
    logic [PrescaleBits-1:0] presc_r;
    logic                    mode_r;
    logic [PrescaleBits-1:0] presc_cnt_r;
    logic                    tick_s;

    // A tick fires on the enabled cycle that completes one prescale period.
    always_comb begin
        tick_s = 1'b0;
        if ((state_r == RUN) && en_i && (presc_cnt_r == presc_r)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Timer FSM: reset beats abort, abort beats start/tick; all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            count_o     <= CNT_ZERO;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            reload_r    <= CNT_ZERO;
            presc_r     <= PRESC_ZERO;
            mode_r      <= 1'b0;
            presc_cnt_r <= PRESC_ZERO;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                // Abort in IDLE only swallows a coincident start.
                if (state_r == RUN) begin
                    state_r <= IDLE;
                    count_o <= CNT_ZERO;
                    busy_o  <= 1'b0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_i) begin
                            if (load_val_i != CNT_ZERO) begin
                                count_o     <= load_val_i;
                                reload_r    <= load_val_i;
                                presc_r     <= prescale_i;
                                mode_r      <= periodic_i;
                                presc_cnt_r <= PRESC_ZERO;
                                busy_o      <= 1'b1;
                                state_r     <= RUN;
                            end else begin
                                count_o <= CNT_ZERO;
                                done_o  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (en_i) begin
                            if (tick_s) begin
                                presc_cnt_r <= PRESC_ZERO;
                                if (count_o > CNT_ONE) begin
                                    count_o <= count_o - CNT_ONE;
                                end else if (mode_r) begin
                                    count_o <= reload_r;
                                    done_o  <= 1'b1;
                                end else begin
                                    count_o <= CNT_ZERO;
                                    done_o  <= 1'b1;
                                    busy_o  <= 1'b0;
                                    state_r <= IDLE;
                                end
                            end else begin
                                presc_cnt_r <= presc_cnt_r + PRESC_ONE;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        count_o <= CNT_ZERO;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: per-cycle vector table plus hand-written
// sequences for enable gating and the full-range count.
module tb_down_timer;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, periodic_i, en_i, abort_i;
    logic [7:0] load_val_i;
    logic [3:0] prescale_i;
    logic [7:0] count_o;
    logic       busy_o, done_o;

    int n_vec  = 0;
    int n_miss = 0;

    down_timer #(.Bits(8), .PrescaleBits(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .load_val_i(load_val_i),
        .periodic_i(periodic_i), .prescale_i(prescale_i), .en_i(en_i),
        .abort_i(abort_i), .count_o(count_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] load;
        logic       per;
        logic [3:0] presc;
        logic       en;
        logic       abort;
        logic [7:0] ec;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [7:0] l,
                                input logic p, input logic [3:0] ps, input logic e,
                                input logic a, input logic [7:0] ec, input logic eb,
                                input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.load = l; v.per = p; v.presc = ps;
        v.en = e; v.abort = a; v.ec = ec; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [7:0] l,
                         input logic p, input logic [3:0] ps, input logic e,
                         input logic a);
        rst_i = r; start_i = s; load_val_i = l; periodic_i = p;
        prescale_i = ps; en_i = e; abort_i = a;
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.rst, v.start, v.load, v.per, v.presc, v.en, v.abort);
        n_vec++;
        chk($sformatf("vec%0d count_o", idx), int'(count_o), int'(v.ec));
        chk($sformatf("vec%0d busy_o", idx), int'(busy_o), int'(v.eb));
        chk($sformatf("vec%0d done_o", idx), int'(done_o), int'(v.ed));
    endtask

    initial begin
        int done_cyc;
        int pulses;
        rst_i = 1'b1; start_i = 1'b0; load_val_i = 8'd0; periodic_i = 1'b0;
        prescale_i = 4'd0; en_i = 1'b0; abort_i = 1'b0;

        // reset, idle
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // one-shot L=5 P=0
        vq.push_back(mk(0, 1, 5, 0, 0, 1, 0, 5, 1, 0));
        for (int k = 4; k >= 1; k--) vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'(k), 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // prescale L=3 P=2: each value held three cycles
        vq.push_back(mk(0, 1, 3, 0, 2, 1, 0, 3, 1, 0));
        for (int k = 0; k < 8; k++) vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'(3 - (k + 1) / 3), 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // start during done cycle, then start held in RUN ignored
        vq.push_back(mk(0, 1, 2, 0, 0, 1, 0, 2, 1, 0));
        vq.push_back(mk(0, 1, 7, 1, 3, 1, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // L=0 started in the done cycle: lone done pulse, busy stays low
        vq.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // periodic L=4 P=0, then abort
        vq.push_back(mk(0, 1, 4, 1, 0, 1, 0, 4, 1, 0));
        for (int r = 0; r < 2; r++) begin
            for (int k = 3; k >= 1; k--) vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'(k), 1, 0));
            vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4, 1, 1));
        end
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // abort+start in IDLE drops the start
        vq.push_back(mk(0, 1, 6, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // reset mid-RUN with abort and start high
        vq.push_back(mk(0, 1, 9, 0, 0, 1, 0, 9, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8, 1, 0));
        vq.push_back(mk(1, 1, 5, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // abort at M, restart at M+1
        vq.push_back(mk(0, 1, 3, 0, 0, 1, 0, 3, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 1, 2, 0, 0, 1, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        // en low freezes the count
        vq.push_back(mk(0, 1, 2, 0, 0, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

        foreach (vq[i]) apply(vq[i], i);

        // enable gating: L=6 P=1, en low on edges 5..9; done expected at 12+5
        drive(0, 1, 6, 0, 1, 1, 0);
        done_cyc = -1;
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            drive(0, 0, 0, 0, 0, (c >= 5 && c <= 9) ? 1'b0 : 1'b1, 0);
            if (done_o) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 4 || c == 9 || c == 10 || c == 11) begin
                n_vec++;
                chk($sformatf("gate count@%0d", c), int'(count_o), (c == 11) ? 3 : 4);
            end
        end
        n_vec++;
        chk("gate done cycle", done_cyc, 17);
        n_vec++;
        chk("gate done pulses", pulses, 1);
        n_vec++;
        chk("gate busy end", int'(busy_o), 0);

        // full-range L=255 P=0 completes after 255 ticks
        drive(0, 1, 255, 0, 0, 1, 0);
        n_vec++;
        chk("L255 start count", int'(count_o), 255);
        done_cyc = -1;
        for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            if (c == 128) begin
                n_vec++;
                chk("L255 count@128", int'(count_o), 127);
            end
            if (done_o) done_cyc = c;
        end
        n_vec++;
        chk("L255 done cycle", done_cyc, 255);
        n_vec++;
        chk("L255 final count", int'(count_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
